// File: rtl/tx_coding_pkg.sv
// Shared 802.11a convolutional coding definitions: generators, rate codes and
// puncture keep-mask table, used by both the transmit encoder and the depuncturer.
package tx_coding_pkg;

   localparam int K = 7;
   localparam logic [K-1:0] G0 = 7'o133;
   localparam logic [K-1:0] G1 = 7'o171;

   typedef enum logic [1:0] {
      RATE_1_2  = 2'd0,
      RATE_2_3  = 2'd1,
      RATE_3_4  = 2'd2,
      RATE_RSVD = 2'd3
   } rate_e;

   // One encoded input: both mother-code bits, which of them survive, end-of-frame flag.
   typedef struct packed {
      logic       a;
      logic       b;
      logic [1:0] keep;   // {keep A, keep B}
      logic       last;
   } coded_pair_t;

   function automatic logic [1:0] punct_period(input rate_e r);
      case (r)
         RATE_2_3: return 2'd2;
         RATE_3_4: return 2'd3;
         default:  return 2'd1;
      endcase
   endfunction

   function automatic logic [1:0] punct_keep(input rate_e r, input logic [1:0] ph);
      case (r)
         RATE_2_3: return (ph == 2'd1) ? 2'b10 : 2'b11;
         RATE_3_4: return (ph == 2'd1) ? 2'b10 : (ph == 2'd2) ? 2'b01 : 2'b11;
         default:  return 2'b11;
      endcase
   endfunction

   function automatic logic [1:0] punct_next(input rate_e r, input logic [1:0] ph);
      return (ph + 2'd1 >= punct_period(r)) ? 2'd0 : ph + 2'd1;
   endfunction

   // sr[K-2] is the previous bit (s1), sr[0] the oldest (s6); returns {A, B}.
   function automatic logic [1:0] conv_enc(input logic x, input logic [K-2:0] sr);
      logic [K-1:0] v;
      v = {x, sr};
      return {^(v & G0), ^(v & G1)};
   endfunction

endpackage

// File: rtl/conv_puncture_ser.sv
// Pair buffer that applies the keep mask and emits surviving coded bits A before B,
// one per valid/ready handshake, from registered outputs.
module conv_puncture_ser
   import tx_coding_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  coded_pair_t i_pair,
   input  logic        i_out_ready,
   output logic        o_can_load,
   output logic        o_out_valid,
   output logic        o_out_bit,
   output logic        o_out_last,
   output logic        o_done
);

   logic r_valid, r_bit, r_nxt, r_two, r_last_pair, r_olast;
   logic w_hs, w_final;

   assign w_hs    = r_valid & i_out_ready;
   assign w_final = w_hs & ~r_two;
   // Refill allowed in the same cycle the final kept bit leaves, so there is no bubble.
   assign o_can_load  = ~r_valid | w_final;
   assign o_done      = w_final & r_olast;
   assign o_out_valid = r_valid;
   assign o_out_bit   = r_bit;
   assign o_out_last  = r_olast;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid     <= 1'b0;
         r_bit       <= 1'b0;
         r_nxt       <= 1'b0;
         r_two       <= 1'b0;
         r_last_pair <= 1'b0;
         r_olast     <= 1'b0;
      end else if (i_load) begin
         r_valid     <= 1'b1;
         r_bit       <= i_pair.keep[1] ? i_pair.a : i_pair.b;
         r_nxt       <= i_pair.b;
         r_two       <= &i_pair.keep;
         r_last_pair <= i_pair.last;
         r_olast     <= i_pair.last & ~(&i_pair.keep);
      end else if (w_hs) begin
         if (r_two) begin
            r_bit   <= r_nxt;
            r_two   <= 1'b0;
            r_olast <= r_last_pair;
         end else begin
            r_valid <= 1'b0;
            r_olast <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/conv_encoder_tx.sv
// 802.11a K=7 rate-1/2 convolutional encoder with 2/3 and 3/4 puncturing and
// zero-tail termination; serialises kept bits toward the interleaver.
module conv_encoder_tx
   import tx_coding_pkg::*;
#(
   parameter int MAX_FRAME_BITS = 4095,
   parameter int TAIL_BITS      = 6
)(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_rate_sel,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   input  logic       i_in_bit,
   input  logic       i_in_last,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic       o_out_bit,
   output logic       o_out_last,
   output logic       o_busy
);

   localparam int CNT_W  = $clog2(MAX_FRAME_BITS + 1);
   localparam int TCNT_W = $clog2(TAIL_BITS + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_e;

   state_e           r_state, w_state_nxt;
   logic [K-2:0]     r_sr;
   rate_e            r_rate, w_rate;
   logic [1:0]       r_phase, w_phase;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [TCNT_W-1:0] r_tcnt;
   logic             w_can_load, w_done, w_accept, w_tail_inj, w_load, w_x, w_last_data;
   logic [1:0]       w_ab;
   coded_pair_t      w_pair;

   // Frame-start values come straight from the inputs so the first bit needs no setup cycle.
   assign w_rate = (r_state == S_IDLE) ? rate_e'(i_rate_sel) : r_rate;
   assign w_phase = (r_state == S_IDLE) ? 2'd0 : r_phase;
   assign w_cnt   = (r_state == S_IDLE) ? '0 : r_cnt;

   always_comb begin
      o_in_ready = 1'b0;
      case (r_state)
         S_IDLE:  o_in_ready = 1'b1;
         S_DATA:  o_in_ready = w_can_load;
         default: o_in_ready = 1'b0;
      endcase
      o_in_ready = o_in_ready & ~i_reset;
   end

   assign w_accept    = i_in_valid & o_in_ready;
   assign w_tail_inj  = (r_state == S_TAIL) & w_can_load & (r_tcnt != TCNT_W'(TAIL_BITS));
   assign w_load      = w_accept | w_tail_inj;
   assign w_x         = w_accept & i_in_bit;
   assign w_last_data = i_in_last | (w_cnt == CNT_W'(MAX_FRAME_BITS - 1));
   assign w_ab        = conv_enc(w_x, r_sr);

   always_comb begin
      w_pair.a    = w_ab[1];
      w_pair.b    = w_ab[0];
      w_pair.keep = punct_keep(w_rate, w_phase);
      w_pair.last = w_tail_inj & (r_tcnt == TCNT_W'(TAIL_BITS - 1));
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_last_data ? S_TAIL : S_DATA;
         S_DATA: if (w_accept && w_last_data) w_state_nxt = S_TAIL;
         S_TAIL: if (w_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_rate  <= RATE_1_2;
         r_phase <= 2'd0;
         r_cnt   <= '0;
         r_tcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_sr    <= {w_x, r_sr[K-2:1]};
            r_phase <= punct_next(w_rate, w_phase);
            r_rate  <= w_rate;
         end
         if (w_accept)   r_cnt  <= w_cnt + CNT_W'(1);
         if (w_tail_inj) r_tcnt <= r_tcnt + TCNT_W'(1);
         if (w_done) begin
            r_sr    <= '0;
            r_phase <= 2'd0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
         end
      end
   end

   conv_puncture_ser u_ser (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_load      (w_load),
      .i_pair      (w_pair),
      .i_out_ready (i_out_ready),
      .o_can_load  (w_can_load),
      .o_out_valid (o_out_valid),
      .o_out_bit   (o_out_bit),
      .o_out_last  (o_out_last),
      .o_done      (w_done)
   );

   assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed frame vectors for conv_encoder_tx: coded streams, out_last position,
// accept spacing, backpressure, mid-frame reset and frame-length saturation.
module tb_conv_encoder_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] rate_sel = 2'd0;
   logic       in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid, out_bit, out_last, busy;

   always #5 clk = ~clk;

   conv_encoder_tx dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_rate_sel  (rate_sel),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_bit    (in_bit),
      .i_in_last   (in_last),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_bit   (out_bit),
      .o_out_last  (out_last),
      .o_busy      (busy)
   );

   typedef struct {
      logic [1:0]  rate;
      int          nbits;
      logic [63:0] data;   // bit k of the frame is data[nbits-1-k]
      int          pct;    // out_ready probability in percent
      int          exp_n;
      logic [63:0] exp;    // first emitted bit is exp[exp_n-1]
      logic [11:0] gaps;   // accept spacing nibbles, gap1 in [3:0]; 0 = unchecked
   } vec_t;

   vec_t tv[7];
   int n_vec = 0, n_bad = 0;

   logic [63:0] r_got;
   int r_n, r_lastpos, r_nacc, r_acc[4];
   logic r_timeout;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic bitof(input logic [63:0] d, input int n, input int k);
      int p;
      p = n - 1 - k;
      return (p >= 0 && p < 64) ? d[p] : 1'b0;
   endfunction

   task automatic run_frame(input logic [1:0] rate, input int nbits, input logic [63:0] data,
                            input bit use_last, input int pct, input int max_cyc);
      logic stall, p_bit, p_last, in_hs, out_hs;
      r_got = '0; r_n = 0; r_lastpos = -1; r_nacc = 0; r_timeout = 1'b1;
      stall = 1'b0; p_bit = 1'b0; p_last = 1'b0;
      in_valid  = 1'b1;
      in_bit    = bitof(data, nbits, 0);
      in_last   = use_last && (nbits == 1);
      rate_sel  = rate;
      out_ready = ($urandom_range(99) < pct);
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (stall) check("stall_hold", {61'd0, out_valid, out_bit, out_last}, {61'd0, 1'b1, p_bit, p_last});
         if (out_valid && !out_ready) check("no_accept_stalled", {63'd0, in_ready}, 64'd0);
         if (r_nacc > 0) check("busy_mid", {63'd0, busy}, 64'd1);
         in_hs  = in_valid & in_ready;
         out_hs = out_valid & out_ready;
         if (in_hs) begin
            if (r_nacc < 4) r_acc[r_nacc] = c;
            r_nacc++;
         end
         if (out_hs) begin
            r_got = {r_got[62:0], out_bit};
            if (out_last) r_lastpos = r_n;
            r_n++;
         end
         stall = out_valid & ~out_ready; p_bit = out_bit; p_last = out_last;
         @(posedge clk); #1;
         if (out_hs && p_last) begin
            r_timeout = 1'b0;
            in_valid = 1'b0; in_last = 1'b0;
            break;
         end
         if (in_hs) begin
            if (r_nacc < nbits) begin
               in_bit  = bitof(data, nbits, r_nacc);
               in_last = use_last && (r_nacc == nbits - 1);
            end else begin
               in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b1;
               rate_sel = ~rate;   // must be ignored for the rest of the frame
            end
         end
         out_ready = ($urandom_range(99) < pct);
      end
      if (r_timeout) begin
         n_vec++; n_bad++;
         $display("FAIL frame_timeout: got no out_last handshake, expected one within %0d cycles", max_cyc);
         in_valid = 1'b0; in_last = 1'b0;
      end
   endtask

   initial begin
      tv[0] = '{2'd0, 1, 64'b1,   100, 14, 64'b11011111001011,   12'h000};
      tv[1] = '{2'd2, 3, 64'b100, 100, 12, 64'b110111001100,     12'h012};
      tv[2] = '{2'd1, 4, 64'b0,   100, 15, 64'b0,                12'h212};
      tv[3] = '{2'd3, 1, 64'b1,   100, 14, 64'b11011111001011,   12'h000};
      tv[4] = '{2'd1, 1, 64'b1,   100, 11, 64'b11011100111,      12'h000};
      tv[5] = '{2'd0, 2, 64'b11,  100, 16, 64'b1110100011100111, 12'h002};
      tv[6] = '{2'd0, 2, 64'b11,  30,  16, 64'b1110100011100111, 12'h000};

      // Reset state
      #12;
      check("rst_in_ready",  {63'd0, in_ready},  64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_bit",   {63'd0, out_bit},   64'd0);
      check("rst_out_last",  {63'd0, out_last},  64'd0);
      check("rst_busy",      {63'd0, busy},      64'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // Frames run back to back: each starts the cycle after the previous out_last
      for (int i = 0; i < 7; i++) begin
         run_frame(tv[i].rate, tv[i].nbits, tv[i].data, 1'b1, tv[i].pct, 400);
         check($sformatf("v%0d_count", i),   r_n,       tv[i].exp_n);
         check($sformatf("v%0d_stream", i),  r_got,     tv[i].exp);
         check($sformatf("v%0d_lastpos", i), r_lastpos, tv[i].exp_n - 1);
         check($sformatf("v%0d_accepts", i), r_nacc,    tv[i].nbits);
         check($sformatf("v%0d_busy_end", i), {63'd0, busy}, 64'd0);
         check($sformatf("v%0d_ready_end", i), {63'd0, in_ready}, 64'd1);
         for (int j = 0; j < 3; j++)
            if (tv[i].gaps[4*j +: 4] != 4'd0 && r_nacc > j + 1)
               check($sformatf("v%0d_gap%0d", i, j + 1), r_acc[j+1] - r_acc[j], tv[i].gaps[4*j +: 4]);
      end

      // Reset in the middle of the tail
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; rate_sel = 2'd0; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("pre_reset_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      #1;
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_busy",      {63'd0, busy},      64'd0);
      check("midrst_in_ready",  {63'd0, in_ready},  64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      run_frame(2'd0, 1, 64'b1, 1'b1, 100, 400);
      check("postrst_count",  r_n,   14);
      check("postrst_stream", r_got, 64'b11011111001011);

      // No in_last: frame length saturates and forces termination
      run_frame(2'd0, 5000, 64'b0, 1'b0, 100, 12000);
      check("sat_accepts", r_nacc,    4095);
      check("sat_count",   r_n,       8202);
      check("sat_lastpos", r_lastpos, 8201);
      check("sat_stream",  r_got,     64'd0);
      check("sat_busy_end", {63'd0, busy}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Transmit-side 802.11a convolutional encoder: K=7, generators g0=133 (octal) and g1=171 (octal), mother rate 1/2.
- Optional puncturing to 2/3 or 3/4. Appends the 6-bit zero tail.
- Serialises the kept coded bits one per cycle toward the interleaver.
- Produces exactly the stream the receive-side Viterbi decoder consumes.

Parameters:
- MAX_FRAME_BITS, 4095: maximum data bits per frame. Sizes the frame bit counter (12 bits).
- TAIL_BITS, 6: zero bits appended after the last data bit. Equals K-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- rate_sel  input  2  sampled on the first accepted bit of a frame: 0=1/2, 1=2/3, 2=3/4, 3=treated as 1/2
- in_valid  input  1  in_bit/in_last valid
- in_ready  output  1  encoder accepts input this cycle
- in_bit  input  1  uncoded data bit
- in_last  input  1  marks the final data bit of the frame
- out_valid  output  1  out_bit valid
- out_ready  input  1  downstream accepts out_bit
- out_bit  output  1  coded, punctured bit
- out_last  output  1  marks the final coded bit of the frame, i.e. the last kept bit of the last tail bit
- busy  output  1  high from first accepted bit until the out_last handshake

Behaviour:
- Only one clock, clk. reset is asynchronous and active-high.
- Reset values: shift register 0, state IDLE, pair buffer empty, in_ready=0 during reset, out_valid=0, out_bit=0, out_last=0, busy=0, puncture phase 0.
- Encoding uses the delay line s[1..6] (s[1] = previous bit) and input x:
  - A = x^s2^s3^s5^s6
  - B = x^s1^s2^s3^s6
  - Then shift: s[1] <= x.
- Puncturing keep-masks, indexed by puncture phase (resets to 0 at frame start, advances once per encoded input, data or tail):
  - 1/2: period 1, keep {A,B}.
  - 2/3: period 2. Phase 0 keep {A,B}; phase 1 keep {A}.
  - 3/4: period 3. Phase 0 keep {A,B}; phase 1 keep {A}; phase 2 keep {B}.
  - Every phase keeps at least one bit.
- Pair buffer: holds A, B, keep mask and a last flag. Kept bits are emitted A before B, one per out handshake.
- States:
  - IDLE: in_ready=1. On in_valid, latch rate_sel, encode, load the buffer, go to DATA. If in_last is also set, go to TAIL instead.
  - DATA: in_ready=1 when the buffer is empty, or when its final kept bit is handshaking this cycle (look-ahead, zero-bubble). On accept, encode and load. If in_last, go to TAIL.
  - TAIL: in_ready=0. Internally inject TAIL_BITS zeros with the same buffer/refill rule. The kept bits of the last tail bit carry out_last on the final one. On that handshake, go to IDLE, clear the shift register, clear busy.
- Throughput (continuous out_ready):
  - 1/2: one input per 2 cycles.
  - 3/4: inputs every 2,1,1 cycles.
- Backpressure: out_bit, out_last and out_valid hold stable while out_valid && !out_ready.
- Frame counter: saturating at MAX_FRAME_BITS. Reaching it forces the current bit to be treated as in_last.
- No partial puncture-period padding: the frame simply ends after the kept bits of the last tail bit.
- Reset mid-frame: all state is discarded immediately and the output stream is abandoned. No out_last is issued.
- rate_sel changes mid-frame are ignored.
- Output register drives out_bit/out_valid (no combinational in->out path). in_ready depends combinationally on out_ready (look-ahead only).

Decomposition:
- Shared package (tx_coding_pkg): K, generator constants G0=7'o133 and G1=7'o171, rate encodings, the puncture keep-mask table. The decoder's depuncturer uses the same package.
- One natural sub-module, conv_puncture_ser: the pair buffer, keep-mask application and A/B serialisation with the valid/ready output. The parent owns the FSM, shift register and counters.

Test Plan:
- Impulse at rate 1/2: frame of one bit, 1 (in_last=1), out_ready=1 -> 14 bits 11 01 11 11 00 10 11 (A/B pairs), out_last on the 14th, busy falls after it.
- Rate 3/4: data 1,0,0 then tail -> 9 inputs give 12 kept bits. The first four are A0 B0 A1 B2 = 1,1,0,1; out_last on the 12th.
- Rate 2/3: all-zero 4-bit frame -> 10 inputs give 15 kept bits, all 0. Check phase pattern 2,1,2,1,... bits per input.
- Backpressure: random out_ready at 30% during a rate-1/2 frame -> bitstream identical to the out_ready=1 run. out_bit stable while stalled. No input accepted while the buffer is full and not draining.
- Reset asserted mid-TAIL -> out_valid=0 and busy=0 immediately. The next frame's impulse response matches the first test (shift register cleared).
- Back-to-back frames: second frame's first bit presented the cycle after out_last -> accepted in IDLE, puncture phase restarts at 0, rate_sel re-sampled.
